// File: rtl/prior_state_mac_serial.sv
// prior_state_mac_serial: Kalman prior-state predictor x_prior = A*x + B*u,
// computed with a single multiplier and accumulator time-shared over all products.
module prior_state_mac_serial #(
    parameter int N    = 16,
    parameter int FRAC = 8,
    parameter int NX   = 2,
    parameter int NU   = 2,
    parameter int SAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    output logic              busy,
    input  logic [NX*N-1:0]    x_in,
    input  logic [NX*NX*N-1:0] a_in,
    input  logic [NU*N-1:0]    u_in,
    input  logic [NX*NU*N-1:0] b_in,
    output logic              done,
    output logic              ovf,
    output logic [NX*N-1:0]    x_prior
);
    localparam int K  = NX + NU;
    localparam int W  = 2*N + $clog2(K);
    localparam int KW = $clog2(K + 1);
    localparam int RW = $clog2(NX + 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t state, state_nx;

    logic [NX*N-1:0]    x_r, shadow;
    logic [NX*NX*N-1:0] a_r;
    logic [NU*N-1:0]    u_r;
    logic [NX*NU*N-1:0] b_r;
    logic [KW-1:0]      k;
    logic [RW-1:0]      row;
    logic signed [W-1:0]   acc, sum, shifted;
    logic signed [N-1:0]   m_a, m_b;
    logic signed [2*N-1:0] prod;
    logic [N-1:0]       narrowed;
    logic               last_k, last_row, row_ovf, ovf_acc;
    int                 ka, kb;

    // Operands are forced to zero outside MAC so nothing undefined reaches the accumulator
    always_comb begin
        ka  = int'(k) < NX ? int'(k) : 0;
        kb  = int'(k) >= NX ? int'(k) - NX : 0;
        m_a = '0;
        m_b = '0;
        if (state == MAC) begin
            m_a = int'(k) < NX ? a_r[(int'(row)*NX + ka)*N +: N] : b_r[(int'(row)*NU + kb)*N +: N];
            m_b = int'(k) < NX ? x_r[ka*N +: N] : u_r[kb*N +: N];
        end
    end

    assign prod     = (2*N)'(m_a) * (2*N)'(m_b);
    assign sum      = acc + W'(prod);
    assign shifted  = sum >>> FRAC;
    assign row_ovf  = !(&shifted[W-1:N-1]) && (|shifted[W-1:N-1]);
    assign narrowed = (row_ovf && SAT != 0) ? (shifted[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                                            : shifted[N-1:0];
    assign last_k   = k == KW'(K - 1);
    assign last_row = row == RW'(NX - 1);
    assign busy     = state != IDLE;
    assign ready    = ~busy;

    always_comb begin
        state_nx = (state == IDLE && start)               ? MAC  :
                   (state == MAC && last_k && last_row)   ? DONE :
                   (state == DONE)                        ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_r     <= '0;
            a_r     <= '0;
            u_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            k       <= '0;
            row     <= '0;
            shadow  <= '0;
            ovf_acc <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            x_prior <= '0;
        end else begin
            state <= state_nx;
            done  <= state == DONE;
            if (state == IDLE && start) begin
                x_r     <= x_in;
                a_r     <= a_in;
                u_r     <= u_in;
                b_r     <= b_in;
                acc     <= '0;
                k       <= '0;
                row     <= '0;
                ovf_acc <= 1'b0;
            end
            if (state == MAC) begin
                if (last_k) begin
                    shadow[int'(row)*N +: N] <= narrowed;
                    acc     <= '0;
                    k       <= '0;
                    row     <= row + 1'b1;
                    ovf_acc <= ovf_acc | row_ovf;
                end else begin
                    acc <= sum;
                    k   <= k + 1'b1;
                end
            end
            // All rows become visible together so x_prior never shows a partial result
            if (state == DONE) begin
                x_prior <= shadow;
                ovf     <= ovf_acc;
            end
        end
    end
endmodule

// File: tb/tb_prior_state_mac_serial.sv
// tb_prior_state_mac_serial: directed vectors for NX=NU=2 (saturating and wrapping builds)
// plus random NX=3, NU=1 operations checked against a reference model.
module tb_prior_state_mac_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [31:0] x_in = '0, u_in = '0;
    logic [63:0] a_in = '0, b_in = '0;
    logic        ready, busy, done, ovf, ready_w, busy_w, done_w, ovf_w;
    logic [31:0] x_prior, x_prior_w;

    logic         start3 = 1'b0;
    logic [47:0]  x3 = '0, b3 = '0, xp3;
    logic [143:0] a3 = '0;
    logic [15:0]  u3 = '0;
    logic         ready3, busy3, done3, ovf3;

    prior_state_mac_serial #(.N(16), .FRAC(8), .NX(2), .NU(2), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .busy(busy),
        .x_in(x_in), .a_in(a_in), .u_in(u_in), .b_in(b_in),
        .done(done), .ovf(ovf), .x_prior(x_prior));

    prior_state_mac_serial #(.N(16), .FRAC(8), .NX(2), .NU(2), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready_w), .busy(busy_w),
        .x_in(x_in), .a_in(a_in), .u_in(u_in), .b_in(b_in),
        .done(done_w), .ovf(ovf_w), .x_prior(x_prior_w));

    prior_state_mac_serial #(.N(16), .FRAC(8), .NX(3), .NU(1), .SAT(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .ready(ready3), .busy(busy3),
        .x_in(x3), .a_in(a3), .u_in(u3), .b_in(b3),
        .done(done3), .ovf(ovf3), .x_prior(xp3));

    typedef struct {
        string       name;
        logic [63:0] a, b;
        logic [31:0] x, u, es, ew;
        logic        ov;
    } vec_t;

    int passed = 0, total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic op2(input vec_t v, output int lat);
        @(negedge clk);
        chk({v.name, " ready"}, {63'd0, ready}, 64'd1);
        a_in = v.a; b_in = v.b; x_in = v.x; u_in = v.u;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic gold3(input logic [143:0] a, input logic [47:0] x, input logic [15:0] u,
                         input logic [47:0] b, output logic [47:0] y, output logic o);
        longint s, sh;
        o = 1'b0;
        y = '0;
        for (int r = 0; r < 3; r++) begin
            s = 0;
            for (int c = 0; c < 3; c++)
                s += longint'(shortint'(a[(r*3+c)*16 +: 16])) * longint'(shortint'(x[c*16 +: 16]));
            s += longint'(shortint'(b[r*16 +: 16])) * longint'(shortint'(u));
            sh = s >>> 8;
            if (sh > 32767) begin y[r*16 +: 16] = 16'h7FFF; o = 1'b1; end
            else if (sh < -32768) begin y[r*16 +: 16] = 16'h8000; o = 1'b1; end
            else y[r*16 +: 16] = sh[15:0];
        end
    endtask

    vec_t vt[9];

    initial begin
        int lat, dn, when, bad, bbad;
        logic [31:0] got;
        logic [47:0] y3;
        logic        o3;

        // name, a={A11,A10,A01,A00}, b={B11,B10,B01,B00}, x={x1,x0}, u={u1,u0}, x_prior sat, x_prior wrap, ovf
        vt[0] = '{"ident",  64'h0100_0000_0000_0100, 64'h0, 32'hFF00_0200, 32'h4321_1234, 32'hFF00_0200, 32'hFF00_0200, 1'b0};
        vt[1] = '{"mixed",  64'h0100_0000_0080_0100, 64'h0080_0000_0000_0080, 32'h0400_0200, 32'hFE00_0200, 32'h0300_0500, 32'h0300_0500, 1'b0};
        vt[2] = '{"floor",  64'h0000_0000_0000_0080, 64'h0, 32'h0000_FFFF, 32'h0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
        vt[3] = '{"satpos", 64'h0000_0000_0000_7FFF, 64'h0, 32'h0000_7FFF, 32'h0, 32'h0000_7FFF, 32'h0000_FF00, 1'b1};
        vt[4] = '{"satneg", 64'h0000_0000_0000_8000, 64'h0, 32'h0000_7FFF, 32'h0, 32'h0000_8000, 32'h0000_0080, 1'b1};
        vt[5] = '{"row1ov", 64'h0000_7FFF_0000_0100, 64'h0, 32'h0000_7FFF, 32'h0, 32'h7FFF_7FFF, 32'hFF00_7FFF, 1'b1};
        vt[6] = '{"bonly",  64'h0, 64'h0000_0100_0100_0000, 32'h1111_2222, 32'hFD00_0300, 32'h0300_FD00, 32'h0300_FD00, 1'b0};
        vt[7] = '{"maxp1",  64'h0000_0000_0100_0100, 64'h0, 32'h0001_7FFF, 32'h0, 32'h0000_7FFF, 32'h0000_8000, 1'b1};
        vt[8] = '{"minex",  64'h0100_0000_0000_0100, 64'h0, 32'h0000_8000, 32'h0, 32'h0000_8000, 32'h0000_8000, 1'b0};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst x_prior", {32'd0, x_prior}, 64'd0);
        chk("rst flags", {60'd0, done, ovf, busy, ready}, 64'h1);
        @(negedge clk) rst_n = 1'b1;

        // Each op starts in the cycle the previous done is seen, so the loop is back-to-back
        foreach (vt[i]) begin
            op2(vt[i], lat);
            chk({vt[i].name, " latency"}, 64'(lat), 64'd9);
            chk({vt[i].name, " x_prior"}, {32'd0, x_prior}, {32'd0, vt[i].es});
            chk({vt[i].name, " ovf"}, {63'd0, ovf}, {63'd0, vt[i].ov});
            chk({vt[i].name, " x_prior wrap"}, {32'd0, x_prior_w}, {32'd0, vt[i].ew});
            chk({vt[i].name, " ovf wrap"}, {62'd0, ovf_w, done_w}, {62'd0, vt[i].ov, 1'b1});
        end

        // start pulses while busy must be ignored; x_prior holds the last result until done
        op2(vt[0], lat);
        @(negedge clk);
        a_in = vt[1].a; b_in = vt[1].b; x_in = vt[1].x; u_in = vt[1].u;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dn = 0; when = 0; bad = 0; bbad = 0; got = '0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            #1;
            if (done) begin dn++; got = x_prior; when = c; end
            else if (c < 9 && x_prior !== vt[0].es) bad++;
            if ((c <= 8 && !busy) || (c == 9 && busy)) bbad++;
            start = (c == 3 || c == 5);
            if (c == 3) begin a_in = vt[0].a; x_in = vt[0].x; b_in = vt[3].a; u_in = 32'h7FFF_7FFF; end
        end
        start = 1'b0;
        chk("hs done count", 64'(dn), 64'd1);
        chk("hs done cycle", 64'(when), 64'd9);
        chk("hs result", {32'd0, got}, {32'd0, vt[1].es});
        chk("hs x_prior held", 64'(bad), 64'd0);
        chk("hs busy window", 64'(bbad), 64'd0);

        // Reset in the middle of an operation aborts it and clears the previous result
        op2(vt[1], lat);
        @(negedge clk);
        a_in = vt[0].a; b_in = vt[0].b; x_in = vt[0].x; u_in = vt[0].u;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort x_prior", {32'd0, x_prior}, 64'd0);
        chk("abort flags", {60'd0, done, ovf, busy, ready}, 64'h1);
        dn = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1 if (done) dn++;
            if (c == 2) rst_n = 1'b1;
        end
        chk("abort no done", 64'(dn), 64'd0);
        op2(vt[6], lat);
        chk("post-reset latency", 64'(lat), 64'd9);
        chk("post-reset x_prior", {32'd0, x_prior}, {32'd0, vt[6].es});

        // NX=3, NU=1 against the reference model
        for (int i = 0; i < 1000; i++) begin
            for (int j = 0; j < 9; j++) a3[j*16 +: 16] = 16'($urandom);
            for (int j = 0; j < 3; j++) begin
                x3[j*16 +: 16] = 16'($urandom);
                b3[j*16 +: 16] = 16'($urandom);
            end
            u3 = 16'($urandom);
            if (i % 4 == 0) a3 = a3 >> 8;
            gold3(a3, x3, u3, b3, y3, o3);
            @(negedge clk);
            chk("nx3 ready", {62'd0, ready3, busy3}, 64'h2);
            start3 = 1'b1;
            @(posedge clk);
            #1 start3 = 1'b0;
            lat = 0;
            while (!done3 && lat < 40) begin
                @(posedge clk);
                #1 lat++;
            end
            chk("nx3 latency", 64'(lat), 64'd13);
            chk("nx3 x_prior", {16'd0, xp3}, {16'd0, y3});
            chk("nx3 ovf", {63'd0, ovf3}, {63'd0, o3});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
